// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, FSM states and helpers shared by the multi-cycle ALU.
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  typedef enum logic [3:0] {
    ALU_ADD   = OP_ADD,
    ALU_SUB   = OP_SUB,
    ALU_AND   = OP_AND,
    ALU_OR    = OP_OR,
    ALU_XOR   = OP_XOR,
    ALU_SLL   = OP_SLL,
    ALU_SRL   = OP_SRL,
    ALU_SRA   = OP_SRA,
    ALU_SLT   = OP_SLT,
    ALU_SLTU  = OP_SLTU,
    ALU_MUL   = OP_MUL,
    ALU_MULHU = OP_MULHU,
    ALU_DIVU  = OP_DIVU,
    ALU_REMU  = OP_REMU,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;
  function automatic logic is_multicycle(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction
endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: operand/result valid-ready bus of the multi-cycle ALU.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   op_ctrl;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  eq;
  logic                  lt;
  logic                  ltu;
  logic                  illegal;
  modport master (
    output in_valid, op_ctrl, op1, op2, out_ready,
    input  in_ready, out_valid, alu_out, eq, lt, ltu, illegal
  );
  modport slave (
    input  in_valid, op_ctrl, op1, op2, out_ready,
    output in_ready, out_valid, alu_out, eq, lt, ltu, illegal
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiply / restoring divide, one bit per cycle (only built with ALU_MULDIV_EN).
`ifdef ALU_MULDIV_EN
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  logic [CW-1:0] cnt;
  alu_op_e op_r;
  logic [DATA_WIDTH-1:0] b_r, hi, lo, b_c, hi_c, lo_c, hi_n, lo_n;
  logic [DATA_WIDTH:0] sum, t, diff;
  logic is_div, ge;
  // The start cycle already performs the first step on the fresh operands.
  always_comb begin
    b_c = start ? b : b_r;
    hi_c = start ? '0 : hi;
    lo_c = start ? a : lo;
    is_div = (start ? op : op_r) inside {ALU_DIVU, ALU_REMU};
    sum = {1'b0, hi_c} + (lo_c[0] ? {1'b0, b_c} : '0);
    t = {hi_c, lo_c[DATA_WIDTH-1]};
    ge = t >= {1'b0, b_c};
    diff = t - {1'b0, b_c};
    hi_n = is_div ? (ge ? diff[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0]) : sum[DATA_WIDTH:1];
    lo_n = is_div ? {lo_c[DATA_WIDTH-2:0], ge} : {sum[0], lo_c[DATA_WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      op_r <= ALU_MUL;
      b_r <= '0;
      hi <= '0;
      lo <= '0;
    end else if (start) begin
      cnt <= CW'(1);
      op_r <= op;
      b_r <= b;
      hi <= hi_n;
      lo <= lo_n;
    end else if (cnt != '0 && cnt != LAST) begin
      cnt <= cnt + 1'b1;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
  assign done = cnt == LAST;
  assign result = op_r inside {ALU_MUL, ALU_DIVU} ? lo : hi;
endmodule
`endif

// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32I ALU with registered result/flags and valid/ready handshake.
// Define ALU_MULDIV_EN to add the iterative MUL/MULHU/DIVU/REMU engine; otherwise those ops are illegal.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input logic clk,
  input logic rst_n,
  alu_multicycle_if.slave bus
);
  alu_state_e state, state_n;
  alu_op_e op;
  logic [OP_WIDTH-1:0] op_raw;
  logic rdy_en, accept, multi, legal, done, eq_c, lt_c, ltu_c;
  logic [DATA_WIDTH-1:0] res, mres;
  logic [SHAMT_W-1:0] shamt;
  assign op_raw = bus.op_ctrl;
  assign op = alu_op_e'(op_raw);
  assign shamt = bus.op2[SHAMT_W-1:0];
  assign accept = bus.in_valid && bus.in_ready;
  assign eq_c = bus.op1 == bus.op2;
  assign lt_c = $signed(bus.op1) < $signed(bus.op2);
  assign ltu_c = bus.op1 < bus.op2;
`ifdef ALU_MULDIV_EN
  assign multi = is_multicycle(op);
  assign legal = op <= ALU_REMU;
  alu_muldiv_seq #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && multi),
    .op(op),
    .a(bus.op1),
    .b(bus.op2),
    .done(done),
    .result(mres)
  );
`else
  assign multi = 1'b0;
  assign legal = op <= ALU_SLTU;
  assign done = 1'b0;
  assign mres = '0;
`endif
  // rdy_en keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state <= state_n;
      rdy_en <= 1'b1;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? (multi ? BUSY : DONE) : IDLE) :
              state == BUSY ? (done ? DONE : BUSY) :
              (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready = rdy_en && state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = bus.op1 + bus.op2;
      ALU_SUB:  res = bus.op1 - bus.op2;
      ALU_AND:  res = bus.op1 & bus.op2;
      ALU_OR:   res = bus.op1 | bus.op2;
      ALU_XOR:  res = bus.op1 ^ bus.op2;
      ALU_SLL:  res = bus.op1 << shamt;
      ALU_SRL:  res = bus.op1 >> shamt;
      ALU_SRA:  res = DATA_WIDTH'($signed(bus.op1) >>> shamt);
      ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, lt_c};
      ALU_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, ltu_c};
      default:  res = '0;
    endcase
  end
  // Flags are latched at accept so they sit beside the result however long it takes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= '0;
      bus.eq <= 1'b0;
      bus.lt <= 1'b0;
      bus.ltu <= 1'b0;
      bus.illegal <= 1'b0;
    end else if (accept) begin
      bus.eq <= eq_c;
      bus.lt <= lt_c;
      bus.ltu <= ltu_c;
      bus.illegal <= !legal;
      if (!multi) bus.alu_out <= legal ? res : '0;
    end else if (state == BUSY && done) begin
      bus.alu_out <= mres;
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random ops checked against a behavioural model of the ALU.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_out = '0;
  logic [3:0] exp_flags = '0;
  always #5 clk = ~clk;
  alu_multicycle_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();
  alu_multicycle dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic bit mdv_on();
`ifdef ALU_MULDIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    if (op >= 4'd10 && op <= 4'd13 && !mdv_on()) return {1'b1, 32'b0};
    case (op)
      4'd0:  return {1'b0, a + b};
      4'd1:  return {1'b0, a - b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, a << b[4:0]};
      4'd6:  return {1'b0, a >> b[4:0]};
      4'd7:  return {1'b0, 32'($signed(a) >>> b[4:0])};
      4'd8:  return 33'($signed(a) < $signed(b));
      4'd9:  return 33'(a < b);
      4'd10: return {1'b0, p[31:0]};
      4'd11: return {1'b0, p[63:32]};
      4'd12: return {1'b0, b == 0 ? 32'hFFFF_FFFF : a / b};
      4'd13: return {1'b0, b == 0 ? a : a % b};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op);
    return (mdv_on() && op >= 4'd10 && op <= 4'd13) ? 33 : 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    int k = 0;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("issue_ready", 64'(bus.in_ready), 64'd1);
    m = model(op, a, b);
    exp_out = m[31:0];
    exp_flags = {a == b, $signed(a) < $signed(b), a < b, m[32]};
    bus.in_valid = 1'b1;
    bus.op_ctrl = op;
    bus.op1 = a;
    bus.op2 = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_ctrl = 4'($urandom);
    bus.op1 = $urandom;
    bus.op2 = $urandom;
  endtask

  task automatic wait_out(input string nm, input int exp_lat);
    int k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) break;
    end
    check({nm, "_latency"}, 64'(k), 64'(exp_lat));
  endtask

  task automatic drain(input int hold);
    repeat (hold) begin
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input int hold);
    issue(op, a, b);
    wait_out(nm, lat(op));
    check(nm, 64'(bus.alu_out), 64'(lit));
    drain(hold);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("mon_out", 64'(bus.alu_out), 64'(exp_out));
      check("mon_flags", 64'({bus.eq, bus.lt, bus.ltu, bus.illegal}), 64'(exp_flags));
      check("mon_in_ready", 64'(bus.in_ready), 64'd0);
    end
  end

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_ctrl = '0;
    bus.op1 = '0;
    bus.op2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_outputs", 64'({bus.out_valid, bus.alu_out, bus.eq, bus.lt, bus.ltu, bus.illegal}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    wait_out("add_wrap", 1);
    check("add_wrap", 64'(bus.alu_out), 64'd0);
    check("add_wrap_flags", 64'({bus.eq, bus.ltu, bus.lt}), 64'b001);
    drain(0);
    issue(4'd1, 32'd5, 32'd5);
    wait_out("sub_eq", 1);
    check("sub_eq", 64'({bus.alu_out, bus.eq}), 64'd1);
    drain(1);
    run("slt", 4'd8, 32'h8000_0000, 32'd1, 32'd1, 0);
    run("sltu", 4'd9, 32'h8000_0000, 32'd1, 32'd0, 0);
    run("sra33", 4'd7, 32'h8000_0000, 32'd33, 32'hC000_0000, 0);
    run("backpressure", 4'd0, 32'd3, 32'd4, 32'd7, 5);
    issue(4'd14, 32'd1, 32'd2);
    wait_out("op14", 1);
    check("op14", 64'({bus.illegal, bus.alu_out}), 64'h1_0000_0000);
    drain(0);
`ifdef ALU_MULDIV_EN
    run("mul", 4'd10, 32'h1_0000, 32'h1_0000, 32'h0, 0);
    run("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 32'h1, 0);
    run("divu", 4'd12, 32'd100, 32'd7, 32'd14, 0);
    run("remu", 4'd13, 32'd100, 32'd7, 32'd2, 1);
    run("divu0", 4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run("remu0", 4'd13, 32'd9, 32'd0, 32'd9, 0);
`else
    issue(4'd10, 32'd6, 32'd7);
    wait_out("op10", 1);
    check("op10", 64'({bus.illegal, bus.alu_out}), 64'h1_0000_0000);
    drain(0);
`endif
    issue(4'd12, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_outputs", 64'({bus.out_valid, bus.alu_out, bus.illegal}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst", 64'({bus.in_ready, bus.out_valid, bus.alu_out}), 64'h1_0000_0000 << 1);
    run("add_after_rst", 4'd0, 32'd20, 32'd22, 32'd42, 0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        2: b = a;
        default: b = $urandom;
      endcase
      issue(op, a, b);
      wait_out("rand", lat(op));
      drain($urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
